// File: rtl/vga_overlay_compositor.sv
// vga_overlay_compositor: 640x480@60 timing with a 160x120 virtual grid, compositing one HUD overlay over a background.
// Build option: define OVERLAY_BLEND_EN to mix overlay hits 50/50 with the background instead of replacing it.
module vga_overlay_compositor #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SCALE_SHIFT = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] bg_r,
    input  logic [7:0] bg_g,
    input  logic [7:0] bg_b,
    input  logic       overlay_on,
    input  logic [7:0] overlay_r,
    input  logic [7:0] overlay_g,
    input  logic [7:0] overlay_b,
    output logic [7:0] vx,
    output logic [7:0] vy,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic          pix_en;
    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_next;
    logic          frame_wrap;
    logic          active0;
    logic          active1;
    logic          hs1;
    logic          vs1;
    logic [7:0]    mix_r;
    logic [7:0]    mix_g;
    logic [7:0]    mix_b;

    assign VGA_SYNC_N = 1'b0;

    always_comb begin
        h_next     = h_cnt + HW'(1);
        v_next     = v_cnt;
        frame_wrap = 1'b0;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            if (v_cnt == V_LAST) begin
                v_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                v_next = v_cnt + VW'(1);
            end
        end
        active0 = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    end

    // VGA_CLK rises on the non-advancing clk edge, i.e. in the middle of each pixel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_en  <= 1'b0;
            VGA_CLK <= 1'b0;
        end else begin
            pix_en  <= ~pix_en;
            VGA_CLK <= ~pix_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                h_cnt       <= h_next;
                v_cnt       <= v_next;
                frame_start <= frame_wrap;
            end
        end
    end

    // Stage 1: virtual coordinates go out here so the overlays have a full pixel to answer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active1 <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            vx      <= 8'd0;
            vy      <= 8'd0;
        end else if (pix_en) begin
            active1 <= active0;
            hs1     <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
            vs1     <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
            vx      <= active0 ? 8'(h_cnt >> SCALE_SHIFT) : 8'd0;
            vy      <= active0 ? 8'(v_cnt >> SCALE_SHIFT) : 8'd0;
        end
    end

    always_comb begin
        mix_r = bg_r;
        mix_g = bg_g;
        mix_b = bg_b;
        if (overlay_on) begin
`ifdef OVERLAY_BLEND_EN
            mix_r = 8'(({1'b0, overlay_r} + {1'b0, bg_r}) >> 1);
            mix_g = 8'(({1'b0, overlay_g} + {1'b0, bg_g}) >> 1);
            mix_b = 8'(({1'b0, overlay_b} + {1'b0, bg_b}) >> 1);
`else
            mix_r = overlay_r;
            mix_g = overlay_g;
            mix_b = overlay_b;
`endif
        end
    end

    // Stage 2: syncs and blank ride along with the colour so they leave the pins together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
        end else if (pix_en) begin
            VGA_HS      <= hs1;
            VGA_VS      <= vs1;
            VGA_BLANK_N <= active1;
            VGA_R       <= active1 ? mix_r : 8'd0;
            VGA_G       <= active1 ? mix_g : 8'd0;
            VGA_B       <= active1 ? mix_b : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_overlay_compositor.sv
// Bench for vga_overlay_compositor: full horizontal timing, a short frame so several frames fit the run.
// Expected pins come from a position/arithmetic model driven by clocks elapsed since reset.
`timescale 1ns/1ps
module tb_vga_overlay_compositor;

    localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VV = 8, VF = 2, VSW = 2, VB = 2;
    localparam int SH = 2;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int FT = HT * VT;

    typedef enum logic [1:0] {M_RANDOM, M_FORCE, M_TABLE} mode_t;

    typedef struct {
        logic        ov_on;
        logic [23:0] ov;
        logic [23:0] bg;
        logic [23:0] exp_rgb;
    } vec_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
    } pins_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] bg_r, bg_g, bg_b;
    logic       overlay_on;
    logic [7:0] overlay_r, overlay_g, overlay_b;
    logic [7:0] vx, vy;
    logic       frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    mode_t       mode = M_RANDOM;
    int          tbl_idx = 0;
    vec_t        vecs[8];
    logic [31:0] hit_mask = 32'h0;
    logic [23:0] bg_seed = 24'h0;
    logic [23:0] ov_seed = 24'h0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        chk_en = 1'b0;

    longint      t = 0;
    logic        exp_clk = 1'b0;
    logic        exp_fs = 1'b0;
    logic [15:0] exp_vxy = 16'h0;
    pins_t       exp_pins = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, rgb: 24'h0};

    always #10 clk = ~clk;

    vga_overlay_compositor #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .clk(clk), .resetn(resetn),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .overlay_on(overlay_on),
        .overlay_r(overlay_r), .overlay_g(overlay_g), .overlay_b(overlay_b),
        .vx(vx), .vy(vy), .frame_start(frame_start),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    function automatic logic hit_at(input int cx, input int cy);
        return hit_mask[(cx + 3 * cy) % 32];
    endfunction

    function automatic logic [23:0] bg_at(input int cx, input int cy);
        return bg_seed ^ {8'(cx), 8'(cy * 29), 8'(cx + cy)};
    endfunction

    function automatic logic [23:0] ov_at(input int cx, input int cy);
        return ov_seed ^ {8'(cy * 53), 8'(cx * 3), 8'(255 - cx)};
    endfunction

    function automatic logic [23:0] compose(input logic on, input logic [23:0] ov, input logic [23:0] bg);
        if (!on) return bg;
`ifdef OVERLAY_BLEND_EN
        return {8'((int'(ov[23:16]) + int'(bg[23:16])) / 2),
                8'((int'(ov[15:8])  + int'(bg[15:8]))  / 2),
                8'((int'(ov[7:0])   + int'(bg[7:0]))   / 2)};
`else
        return ov;
`endif
    endfunction

    // The overlay answers from the DUT's presented coordinates, as a real HUD block would.
    logic [23:0] drv_bg, drv_ov;
    assign overlay_on = (mode == M_TABLE) ? vecs[tbl_idx].ov_on
                      : ((mode == M_FORCE) || hit_at(int'(vx), int'(vy)));
    assign drv_bg = (mode == M_TABLE) ? vecs[tbl_idx].bg : bg_at(int'(vx), int'(vy));
    assign drv_ov = (mode == M_TABLE) ? vecs[tbl_idx].ov : ov_at(int'(vx), int'(vy));
    assign {bg_r, bg_g, bg_b} = drv_bg;
    assign {overlay_r, overlay_g, overlay_b} = drv_ov;

    function automatic logic [15:0] vxy_for(input longint p);
        int h = int'(p % HT);
        int v = int'((p / HT) % VT);
        if (h < HV && v < VV) return {8'(h >> SH), 8'(v >> SH)};
        return 16'h0;
    endfunction

    function automatic pins_t pins_for(input longint p);
        pins_t r;
        int    h = int'(p % HT);
        int    v = int'((p / HT) % VT);
        int    cx = h >> SH;
        int    cy = v >> SH;
        r.hs  = !(h >= HV + HF && h < HV + HF + HSW);
        r.vs  = !(v >= VV + VF && v < VV + VF + VSW);
        r.bn  = (h < HV) && (v < VV);
        r.rgb = 24'h0;
        if (r.bn) begin
            if (mode == M_TABLE)
                r.rgb = compose(vecs[tbl_idx].ov_on, vecs[tbl_idx].ov, vecs[tbl_idx].bg);
            else
                r.rgb = compose((mode == M_FORCE) || hit_at(cx, cy), ov_at(cx, cy), bg_at(cx, cy));
        end
        return r;
    endfunction

    // t counts clk edges since reset; every second edge is a pixel tick k = t/2,
    // coordinates reach vx/vy one tick later and the pins two ticks later.
    always @(posedge clk) begin
        if (!resetn) begin
            t        <= 0;
            exp_clk  <= 1'b0;
            exp_fs   <= 1'b0;
            exp_vxy  <= 16'h0;
            exp_pins <= '{hs: 1'b1, vs: 1'b1, bn: 1'b0, rgb: 24'h0};
        end else begin
            t       <= t + 1;
            exp_clk <= ~t[0];
            exp_fs  <= 1'b0;
            if (t[0]) begin
                exp_fs  <= (((t + 1) / 2) % FT) == 0;
                exp_vxy <= vxy_for((t + 1) / 2 - 1);
                if ((t + 1) / 2 >= 2) exp_pins <= pins_for((t + 1) / 2 - 2);
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0d)", nm, act, req, t);
        end
    endtask

    task automatic applyStimulus(input mode_t m, input int idx);
        mode    = m;
        tbl_idx = idx;
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return VGA_HS;
            1:       return VGA_VS;
            2:       return VGA_BLANK_N;
            default: return frame_start;
        endcase
    endfunction

    task automatic waitLevel(input string nm, input int sel, input logic lvl, input int budget, output int clks);
        clks = 0;
        while (sig_sel(sel) !== lvl && clks < budget) begin
            @(negedge clk);
            clks++;
        end
        if (sig_sel(sel) !== lvl) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: still %b after %0d clks, wanted %b", nm, sig_sel(sel), clks, lvl);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("vga_clk", 64'(VGA_CLK), 64'(exp_clk));
            checkOutput("frame_start", 64'(frame_start), 64'(exp_fs));
            checkOutput("vx_vy", 64'({vx, vy}), 64'(exp_vxy));
            checkOutput("sync_blank", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N}),
                        64'({exp_pins.hs, exp_pins.vs, exp_pins.bn, 1'b0}));
            checkOutput("rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(exp_pins.rgb));
        end
    end

    localparam logic [63:0] RESET_PINS = 64'({16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});

    initial begin
        int     c, w;
        longint ta, tb;
        int     viol;
        int     guard;

        resetn   = 1'b0;
        hit_mask = $urandom;
        bg_seed  = 24'($urandom);
        ov_seed  = 24'($urandom);
`ifdef OVERLAY_BLEND_EN
        vecs[0] = '{1'b1, 24'hFFE040, 24'h000080, 24'h7F7060};
        vecs[2] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3] = '{1'b1, 24'h000000, 24'hFFFFFF, 24'h7F7F7F};
        vecs[5] = '{1'b1, 24'h123456, 24'hABCDEF, 24'h5E80A2};
        vecs[6] = '{1'b1, 24'h010101, 24'h000000, 24'h000000};
`else
        vecs[0] = '{1'b1, 24'hFFE040, 24'h000080, 24'hFFE040};
        vecs[2] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3] = '{1'b1, 24'h000000, 24'hFFFFFF, 24'h000000};
        vecs[5] = '{1'b1, 24'h123456, 24'hABCDEF, 24'h123456};
        vecs[6] = '{1'b1, 24'h010101, 24'h000000, 24'h010101};
`endif
        vecs[1] = '{1'b0, 24'hFFE040, 24'h000080, 24'h000080};
        vecs[4] = '{1'b0, 24'h123456, 24'hABCDEF, 24'hABCDEF};
        vecs[7] = '{1'b0, 24'hFFFFFF, 24'h000000, 24'h000000};
        chk_en = 1'b1;

        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_pins", 64'({vx, vy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
                                       VGA_SYNC_N, VGA_R, VGA_G, VGA_B}), RESET_PINS);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Line timing: hsync position and width, line period, active width.
        waitLevel("hs_fall", 0, 1'b0, 4000, c);
        ta = t;
        checkOutput("hs_start_clk", 64'(ta), 64'(2 * (HV + HF) + 4));
        waitLevel("hs_low_clks", 0, 1'b1, 400, w);
        checkOutput("hs_low_clks", 64'(w), 64'(2 * HSW));
        waitLevel("blank_rise", 2, 1'b1, 2000, c);
        waitLevel("blank_high_clks", 2, 1'b0, 2000, w);
        checkOutput("blank_high_clks", 64'(w), 64'(2 * HV));
        waitLevel("hs_fall2", 0, 1'b0, 2000, c);
        tb = t;
        checkOutput("line_period", 64'(tb - ta), 64'(2 * HT));

        // Frame timing: vsync position and width, first frame_start.
        waitLevel("vs_fall", 1, 1'b0, 20000, c);
        checkOutput("vs_start_clk", 64'(t), 64'(2 * (VV + VF) * HT + 4));
        waitLevel("vs_low_clks", 1, 1'b1, 4000, w);
        checkOutput("vs_low_clks", 64'(w), 64'(2 * VSW * HT));
        waitLevel("frame_start", 3, 1'b1, 10000, c);
        checkOutput("first_frame_start_clk", 64'(t), 64'(2 * FT));

        // Compositing vectors, applied early in the next frame's first active line.
        repeat (10) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 applyStimulus(M_TABLE, i);
            repeat (8) @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("table_vec%0d", i), 64'({VGA_R, VGA_G, VGA_B}),
                        64'(exp_pins.bn ? vecs[i].exp_rgb : 24'h0));
        end

        // Overlay stuck on across a full line including blanking.
        @(posedge clk);
        #1 applyStimulus(M_FORCE, 0);
        viol = 0;
        repeat (1700) begin
            @(negedge clk);
            if (!VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'h0) viol++;
        end
        checkOutput("force_on_blank_rgb", 64'(viol), 64'(0));
        @(posedge clk);
        #1 applyStimulus(M_RANDOM, 0);

        // Reset mid-frame while hsync is low, then time the restart.
        guard = 0;
        do begin
            @(posedge clk);
            #1 guard++;
        end while (!(t[0] == 1'b0 && (t / 2) % HT == 700 && ((t / 2) / HT) % VT == 5) && guard < 2 * FT + 10);
        if (guard >= 2 * FT + 10) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL midframe_position: not reached after %0d clks", guard);
        end
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midframe_reset_pins", 64'({vx, vy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
                                                VGA_SYNC_N, VGA_R, VGA_G, VGA_B}), RESET_PINS);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        waitLevel("restart_frame_start", 3, 1'b1, 2 * FT + 100, c);
        checkOutput("restart_frame_start_clk", 64'(t), 64'(2 * FT));

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
